inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 32 +++
 rtl/inst_queue.sv | 141 ++++++++++++++
 tb/tb_inst_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue_pkg
//  Description : Shared CPU defines: issue modes, pop-count encodings and
//                default instruction-queue dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_queue_pkg;

  // Issue mode constants
  localparam int ISSUE_SINGLE = 0;
  localparam int ISSUE_DUAL   = 1;

  // Pop-count encodings presented by the issue stage
  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_cnt_e;

  // Default instruction-queue dimensions
  localparam int CPU_IQ_DEPTH = 16;
  localparam int CPU_INST_W   = 32;
  localparam int CPU_PC_W     = 32;

  // Number of set bits in a 2-bit slot-valid vector
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Dual-push / dual-pop circular instruction queue between
//                fetch and issue. Registered outputs, no bypass.
//                Optional macro INST_QUEUE_DS_KEEP_EN enables keeping the
//                delay-slot entry on flush (flush_i with flush_keep_i).
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = CPU_IQ_DEPTH,
  parameter int INST_W = CPU_INST_W,
  parameter int PC_W   = CPU_PC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       flush_keep_i,
  input  logic [1:0]                 push_valid_i,
  input  logic [INST_W-1:0]          push_inst0_i,
  input  logic [INST_W-1:0]          push_inst1_i,
  input  logic [PC_W-1:0]            push_pc0_i,
  input  logic [PC_W-1:0]            push_pc1_i,
  output logic                       push_ready_o,
  input  logic [1:0]                 pop_cnt_i,
  output logic [1:0]                 out_valid_o,
  output logic [INST_W-1:0]          out_inst0_o,
  output logic [INST_W-1:0]          out_inst1_o,
  output logic [PC_W-1:0]            out_pc0_o,
  output logic [PC_W-1:0]            out_pc1_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [CNT_W-1:0]  free_cnt;
  logic [1:0]        pop_req;
  logic [1:0]        pop_eff;
  logic [1:0]        push_eff;
  logic [PTR_W-1:0]  tail_p1;
  logic [PTR_W-1:0]  head_p1;
  logic [PTR_W-1:0]  keep_idx;
  logic              keep_hit;
  logic [INST_W-1:0] wr_inst_a;
  logic [PC_W-1:0]   wr_pc_a;

  assign free_cnt     = CNT_W'(DEPTH) - count;
  assign push_ready_o = (free_cnt >= CNT_W'(2));

  // Pop request saturates at two, then is clamped to the current occupancy
  always_comb begin
    pop_req = pop_cnt_i;
    if (pop_cnt_i == 2'd3) pop_req = POP_TWO;
    pop_eff = pop_req;
    if (CNT_W'(pop_req) > count) pop_eff = count[1:0];
  end

  assign push_eff = push_ready_o ? popcount2(push_valid_i) : 2'd0;

  // Compaction: the first valid slot always lands at tail
  assign wr_inst_a = push_valid_i[0] ? push_inst0_i : push_inst1_i;
  assign wr_pc_a   = push_valid_i[0] ? push_pc0_i   : push_pc1_i;

  assign tail_p1  = tail + PTR_W'(1);
  assign head_p1  = head + PTR_W'(1);
  assign keep_idx = head + PTR_W'(pop_eff);

`ifdef INST_QUEUE_DS_KEEP_EN
  // The surviving entry is the oldest one left after this cycle's pop
  assign keep_hit = flush_keep_i && (count > CNT_W'(pop_eff));
`else
  // Keep request has no effect in this build; every flush empties the queue
  assign keep_hit = flush_keep_i & 1'b0;
`endif

  // Storage writes: pushes at tail, or relocation of the kept entry to slot 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (flush_i) begin
        if (keep_hit) begin
          inst_mem[0] <= inst_mem[keep_idx];
          pc_mem[0]   <= pc_mem[keep_idx];
        end
      end else begin
        if (push_eff != 2'd0) begin
          inst_mem[tail] <= wr_inst_a;
          pc_mem[tail]   <= wr_pc_a;
        end
        if (push_eff == 2'd2) begin
          inst_mem[tail_p1] <= push_inst1_i;
          pc_mem[tail_p1]   <= push_pc1_i;
        end
      end
    end
  end

  // Pointer and occupancy update; rst beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= keep_hit ? PTR_W'(1) : '0;
      count <= keep_hit ? CNT_W'(1) : '0;
    end else begin
      head  <= head + PTR_W'(pop_eff);
      tail  <= tail + PTR_W'(push_eff);
      count <= count - CNT_W'(pop_eff) + CNT_W'(push_eff);
    end
  end

  // Registered-state view of head and head+1; invalid slots read as zero
  always_comb begin
    out_valid_o[0] = (count >= CNT_W'(1));
    out_valid_o[1] = (count >= CNT_W'(2));
    out_inst0_o    = out_valid_o[0] ? inst_mem[head]    : '0;
    out_pc0_o      = out_valid_o[0] ? pc_mem[head]      : '0;
    out_inst1_o    = out_valid_o[1] ? inst_mem[head_p1] : '0;
    out_pc1_o      = out_valid_o[1] ? pc_mem[head_p1]   : '0;
  end

  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_queue
//  Description : Scoreboard bench for inst_queue (DEPTH=16). Stimulus pushes
//                expected entries into a queue; a negedge monitor compares
//                the presented head entries and pops on issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  localparam int DEPTH = 16;

`ifdef INST_QUEUE_DS_KEEP_EN
  localparam bit KEEP_BUILD = 1'b1;
`else
  localparam bit KEEP_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, flush_keep_i;
  logic [1:0]  push_valid_i;
  logic [31:0] push_inst0_i, push_inst1_i, push_pc0_i, push_pc1_i;
  logic        push_ready_o;
  logic [1:0]  pop_cnt_i;
  logic [1:0]  out_valid_o;
  logic [31:0] out_inst0_o, out_inst1_o, out_pc0_o, out_pc1_o;
  logic [4:0]  count_o;
  logic        empty_o, full_o;

  int checks = 0;
  int errors = 0;
  entry_t sbq[$];

  inst_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .flush_keep_i (flush_keep_i),
    .push_valid_i (push_valid_i),
    .push_inst0_i (push_inst0_i),
    .push_inst1_i (push_inst1_i),
    .push_pc0_i   (push_pc0_i),
    .push_pc1_i   (push_pc1_i),
    .push_ready_o (push_ready_o),
    .pop_cnt_i    (pop_cnt_i),
    .out_valid_o  (out_valid_o),
    .out_inst0_o  (out_inst0_o),
    .out_inst1_o  (out_inst1_o),
    .out_pc0_o    (out_pc0_o),
    .out_pc1_o    (out_pc1_o),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare visible head entries and retire issued ones
  always @(negedge clk) begin
    int sz;
    int n;
    if (!rst) begin
      sz = sbq.size();
      chk("mon_count", 64'(count_o), 64'(sz));
      chk("mon_valid", 64'(out_valid_o), {62'd0, sz >= 2, sz >= 1});
      chk("mon_empty", 64'(empty_o), 64'(sz == 0));
      chk("mon_full", 64'(full_o), 64'(sz == DEPTH));
      chk("mon_ready", 64'(push_ready_o), 64'((DEPTH - sz) >= 2));
      if (sz >= 1) begin
        chk("mon_pc0", 64'(out_pc0_o), 64'(sbq[0].pc));
        chk("mon_inst0", 64'(out_inst0_o), 64'(sbq[0].inst));
      end else begin
        chk("mon_zero0", {out_pc0_o, out_inst0_o}, 64'd0);
      end
      if (sz >= 2) begin
        chk("mon_pc1", 64'(out_pc1_o), 64'(sbq[1].pc));
        chk("mon_inst1", 64'(out_inst1_o), 64'(sbq[1].inst));
      end else begin
        chk("mon_zero1", {out_pc1_o, out_inst1_o}, 64'd0);
      end
      if (!(flush_i && !(KEEP_BUILD && flush_keep_i))) begin
        n = (pop_cnt_i == 2'd3) ? 2 : int'(pop_cnt_i);
        if (n > sz) n = sz;
        repeat (n) void'(sbq.pop_front());
      end
    end
  end

  // One cycle of stimulus; the expected queue is updated after the edge
  task automatic step(input logic [1:0] pv, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] pc, input logic fl, input logic fk);
    bit acc;
    entry_t e;
    push_valid_i = pv;
    push_pc0_i   = p0;
    push_pc1_i   = p1;
    push_inst0_i = mk_inst(p0);
    push_inst1_i = mk_inst(p1);
    pop_cnt_i    = pc;
    flush_i      = fl;
    flush_keep_i = fk;
    acc = ((DEPTH - sbq.size()) >= 2);
    @(posedge clk);
    #1;
    if (fl) begin
      if (KEEP_BUILD && fk && sbq.size() > 0) begin
        e = sbq[0];
        sbq.delete();
        sbq.push_back(e);
      end else begin
        sbq.delete();
      end
    end else if (acc) begin
      if (pv[0]) sbq.push_back('{pc: p0, inst: mk_inst(p0)});
      if (pv[1]) sbq.push_back('{pc: p1, inst: mk_inst(p1)});
    end
    push_valid_i = 2'b00;
    pop_cnt_i    = 2'd0;
    flush_i      = 1'b0;
    flush_keep_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0; flush_keep_i = 1'b0; push_valid_i = 2'b00; pop_cnt_i = 2'd0;
    push_inst0_i = '0; push_inst1_i = '0; push_pc0_i = '0; push_pc1_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_ready", 64'(push_ready_o), 64'd1);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    rst = 1'b0;

    // Dual push, visible next cycle
    step(2'b11, 32'h100, 32'h104, 2'd0, 1'b0, 1'b0);
    chk("dual_valid", 64'(out_valid_o), 64'd3);
    chk("dual_pc0", 64'(out_pc0_o), 64'h100);
    chk("dual_count", 64'(count_o), 64'd2);

    // Fill to 15, push blocked, then pop reopens
    for (int i = 0; i < 6; i++)
      step(2'b11, 32'h110 + 32'(8 * i), 32'h114 + 32'(8 * i), 2'd0, 1'b0, 1'b0);
    step(2'b01, 32'h140, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("fill15_count", 64'(count_o), 64'd15);
    chk("fill15_ready", 64'(push_ready_o), 64'd0);
    step(2'b11, 32'h150, 32'h154, 2'd0, 1'b0, 1'b0);
    chk("blocked_count", 64'(count_o), 64'd15);
    step(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
    chk("reopen_ready", 64'(push_ready_o), 64'd1);
    chk("reopen_count", 64'(count_o), 64'd14);
    step(2'b11, 32'h160, 32'h164, 2'd0, 1'b0, 1'b0);
    chk("full_flag", 64'(full_o), 64'd1);
    chk("full_count", 64'(count_o), 64'd16);

    // Drain; pop code 3 behaves as 2
    step(2'b00, 32'h0, 32'h0, 2'd3, 1'b0, 1'b0);
    chk("pop3_count", 64'(count_o), 64'd14);
    repeat (7) step(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    chk("drained_empty", 64'(empty_o), 64'd1);

    // Pop clamped to occupancy while pushing
    step(2'b01, 32'h1F0, 32'h0, 2'd0, 1'b0, 1'b0);
    step(2'b01, 32'h200, 32'h0, 2'd2, 1'b0, 1'b0);
    chk("clamp_count", 64'(count_o), 64'd1);
    chk("clamp_pc0", 64'(out_pc0_o), 64'h200);
    step(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);

    // Slot-1-only push compacts to tail
    step(2'b10, 32'h300, 32'h304, 2'd0, 1'b0, 1'b0);
    chk("slot1_count", 64'(count_o), 64'd1);
    chk("slot1_pc0", 64'(out_pc0_o), 64'h304);
    step(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);

    // Wrap: 40 single pushes with trailing pops
    for (int i = 0; i < 40; i++) begin
      step(2'b01, 32'h400 + 32'(4 * i), 32'h0, (i > 0) ? 2'd1 : 2'd0, 1'b0, 1'b0);
      chk("wrap_nofull", 64'(full_o), 64'd0);
    end
    step(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);

    // Steady dual push + dual pop
    for (int i = 0; i < 10; i++)
      step(2'b11, 32'h600 + 32'(8 * i), 32'h604 + 32'(8 * i), 2'd2, 1'b0, 1'b0);
    chk("dual_steady_count", 64'(count_o), 64'd2);

    // Plain flush ignores same-cycle push and pop
    step(2'b11, 32'h500, 32'h504, 2'd1, 1'b1, 1'b0);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_empty", 64'(empty_o), 64'd1);

    // Flush with keep
    step(2'b11, 32'h10, 32'h14, 2'd0, 1'b0, 1'b0);
    step(2'b01, 32'h18, 32'h0, 2'd0, 1'b0, 1'b0);
    step(2'b11, 32'h70, 32'h74, 2'd1, 1'b1, 1'b1);
    if (KEEP_BUILD) begin
      chk("keep_count", 64'(count_o), 64'd1);
      chk("keep_pc0", 64'(out_pc0_o), 64'h14);
      step(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
    end else begin
      chk("nokeep_count", 64'(count_o), 64'd0);
      chk("nokeep_empty", 64'(empty_o), 64'd1);
    end
    // Keep with nothing left after the pop
    step(2'b01, 32'h20, 32'h0, 2'd0, 1'b0, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'd1, 1'b1, 1'b1);
    chk("keep_none_count", 64'(count_o), 64'd0);
    // Queue is usable afterwards
    step(2'b01, 32'h30, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("post_flush_pc0", 64'(out_pc0_o), 64'h30);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
